// File: rtl/fan_pid_pkg.sv
// Shared types and widths for the fan PID update sequencer.
// Build option: PID_ANTIWINDUP_EN selects clamped (back-calculation) output history.
package fan_pid_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StSat
    } pid_state_e;

    // MAC tap order: feed-forward error taps first, then feedback taps
    localparam logic [2:0] TAP_B2 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B0 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A0 = 3'd4;

    localparam int unsigned ADC_BITWIDTH_DEF = 8;

    // Error is set - adc, so it needs one extra bit for the sign
    function automatic int unsigned err_width(input int unsigned adc_w);
        return adc_w + 1;
    endfunction

    // Output history width depends on whether it stores clamped or raw results
    function automatic int unsigned hist_width(input int unsigned adc_w);
`ifdef PID_ANTIWINDUP_EN
        return adc_w + 1;
`else
        return adc_w + 8;
`endif
    endfunction

    localparam int unsigned ERR_W  = err_width(ADC_BITWIDTH_DEF);
    localparam int unsigned HIST_W = hist_width(ADC_BITWIDTH_DEF);

endpackage

// File: rtl/fan_pid_mac.sv
// Shared signed multiply-accumulate unit for the PID sequencer.
// Product is sign-extended (or truncated) to the accumulator width and optionally negated.
module fan_pid_mac
    import fan_pid_pkg::*;
#(
    parameter int unsigned COEF_W = 32,
    parameter int unsigned OP_W   = 16,
    parameter int unsigned ACC_W  = 44
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     acc_en_i,
    input  logic                     neg_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [OP_W-1:0]   op_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int unsigned PROD_W = COEF_W + OP_W;
    localparam int unsigned EXT_W  = (PROD_W > ACC_W) ? PROD_W : ACC_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [EXT_W-1:0]  prod_ext;
    logic        [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_q;

    assign prod     = coef_i * op_i;
    assign prod_ext = EXT_W'(prod);
    assign term     = neg_i ? (~prod_ext[ACC_W-1:0] + 1'b1) : prod_ext[ACC_W-1:0];

    // Accumulator register: clear wins over accumulate
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= acc_q + term;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fan_pid_sequencer.sv
// Time-multiplexed PID (IIR) update sequencer driving the fan PWM duty command.
// Build option: PID_ANTIWINDUP_EN feeds the clamped output back into the u history.
module fan_pid_sequencer
    import fan_pid_pkg::*;
#(
    parameter int unsigned ADC_BITWIDTH  = 8,
    parameter int unsigned COEF_W        = 32,
    parameter int unsigned FRAC_BITWIDTH = 30,
    parameter int unsigned ACC_W         = 44
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick_i,
    input  logic                     enable_i,
    input  logic [ADC_BITWIDTH-1:0]  adc_i,
    input  logic [ADC_BITWIDTH-1:0]  set_i,
    input  logic signed [COEF_W-1:0] b2_i,
    input  logic signed [COEF_W-1:0] b1_i,
    input  logic signed [COEF_W-1:0] b0_i,
    input  logic signed [COEF_W-1:0] a1_i,
    input  logic signed [COEF_W-1:0] a0_i,
    output logic [ADC_BITWIDTH-1:0]  u_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam int unsigned ERR_WIDTH  = err_width(ADC_BITWIDTH);
    localparam int unsigned HIST_WIDTH = hist_width(ADC_BITWIDTH);
    localparam int unsigned OP_WIDTH   = (HIST_WIDTH > ERR_WIDTH) ? HIST_WIDTH : ERR_WIDTH;
    localparam longint      U_MAX      = (longint'(1) << ADC_BITWIDTH) - 1;

    pid_state_e                    state_q;
    logic [2:0]                    tap_q;
    logic signed [ERR_WIDTH-1:0]   e0_q, e1_q, e2_q;
    logic signed [HIST_WIDTH-1:0]  u1_q, u2_q;
    logic [ADC_BITWIDTH-1:0]       u_q;
    logic                          valid_q;
    logic                          overrun_q;

    logic signed [ERR_WIDTH-1:0]   err;
    logic signed [COEF_W-1:0]      coef;
    logic signed [OP_WIDTH-1:0]    op;
    logic                          neg;
    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       shifted;
    logic signed [63:0]            r64;
    logic [ADC_BITWIDTH-1:0]       u_sat;
    logic signed [HIST_WIDTH-1:0]  u_hist;
    logic                          mac_clr;
    logic                          mac_en;

    assign err = {1'b0, set_i} - {1'b0, adc_i};

    // Operand mux: select coefficient/history pair for the current tap
    always_comb begin
        coef = '0;
        op   = '0;
        neg  = 1'b0;
        case (tap_q)
            TAP_B2: begin coef = b2_i; op = OP_WIDTH'(e0_q); end
            TAP_B1: begin coef = b1_i; op = OP_WIDTH'(e1_q); end
            TAP_B0: begin coef = b0_i; op = OP_WIDTH'(e2_q); end
            TAP_A1: begin coef = a1_i; op = OP_WIDTH'(u1_q); neg = 1'b1; end
            TAP_A0: begin coef = a0_i; op = OP_WIDTH'(u2_q); neg = 1'b1; end
            default: ;
        endcase
    end

    assign mac_clr = !enable_i || (state_q == StIdle && tick_i);
    assign mac_en  = enable_i && (state_q == StMac);

    fan_pid_mac #(
        .COEF_W (COEF_W),
        .OP_W   (OP_WIDTH),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (mac_clr),
        .acc_en_i (mac_en),
        .neg_i    (neg),
        .coef_i   (coef),
        .op_i     (op),
        .acc_o    (acc)
    );

    assign shifted = acc >>> FRAC_BITWIDTH;
    assign r64     = 64'(shifted);

    // Saturate the shifted result to the duty range and to the history range
    always_comb begin
        if (r64 < 0) begin
            u_sat = '0;
        end else if (r64 > U_MAX) begin
            u_sat = '1;
        end else begin
            u_sat = r64[ADC_BITWIDTH-1:0];
        end
`ifdef PID_ANTIWINDUP_EN
        u_hist = {1'b0, u_sat};
`else
        if (r64 > ((longint'(1) << (HIST_WIDTH - 1)) - 1)) begin
            u_hist = HIST_WIDTH'((longint'(1) << (HIST_WIDTH - 1)) - 1);
        end else if (r64 < -(longint'(1) << (HIST_WIDTH - 1))) begin
            u_hist = HIST_WIDTH'(-(longint'(1) << (HIST_WIDTH - 1)));
        end else begin
            u_hist = r64[HIST_WIDTH-1:0];
        end
`endif
    end

    // Sequencer FSM with history and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tap_q     <= TAP_B2;
            e0_q      <= '0;
            e1_q      <= '0;
            e2_q      <= '0;
            u1_q      <= '0;
            u2_q      <= '0;
            u_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (!enable_i) begin
            // Disable discards any in-flight update and flushes history
            state_q <= StIdle;
            tap_q   <= TAP_B2;
            e0_q    <= '0;
            e1_q    <= '0;
            e2_q    <= '0;
            u1_q    <= '0;
            u2_q    <= '0;
            u_q     <= '0;
            valid_q <= 1'b0;
            if (tick_i && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tick_i) begin
                        e0_q    <= err;
                        tap_q   <= TAP_B2;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    if (tick_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (tap_q == TAP_A0) begin
                        state_q <= StSat;
                    end else begin
                        tap_q <= tap_q + 3'd1;
                    end
                end
                StSat: begin
                    if (tick_i) begin
                        overrun_q <= 1'b1;
                    end
                    u_q     <= u_sat;
                    e2_q    <= e1_q;
                    e1_q    <= e0_q;
                    u2_q    <= u1_q;
                    u1_q    <= u_hist;
                    valid_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign u_o       = u_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q != StIdle);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fan_pid_sequencer.sv
// Directed self-checking bench for fan_pid_sequencer.
// Expectations for the windup scenario follow the PID_ANTIWINDUP_EN build option.
module tb_fan_pid_sequencer;

    localparam logic signed [31:0] ONE     = 32'sh4000_0000;
    localparam logic signed [31:0] NEG_ONE = -32'sh4000_0000;
    localparam logic signed [31:0] NEAR_TWO = 32'sh7FFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick_i;
    logic              enable_i;
    logic [7:0]        adc_i;
    logic [7:0]        set_i;
    logic signed [31:0] b2_i, b1_i, b0_i, a1_i, a0_i;
    logic [7:0]        u_o;
    logic              valid_o;
    logic              busy_o;
    logic              overrun_o;

    int tests = 0;
    int fails = 0;

    fan_pid_sequencer #(
        .ADC_BITWIDTH  (8),
        .COEF_W        (32),
        .FRAC_BITWIDTH (30),
        .ACC_W         (44)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick_i),
        .enable_i  (enable_i),
        .adc_i     (adc_i),
        .set_i     (set_i),
        .b2_i      (b2_i),
        .b1_i      (b1_i),
        .b0_i      (b0_i),
        .a1_i      (a1_i),
        .a0_i      (a0_i),
        .u_o       (u_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        enable_i = 1'b0;
        step();
        enable_i = 1'b1;
        step();
    endtask

    // Issue one tick and follow it through to the result; reports value and timing health
    task automatic run_tick(output logic [7:0] u_seen, output bit timing_ok);
        timing_ok = 1'b1;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        if (busy_o !== 1'b1) timing_ok = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (valid_o !== 1'b0 || busy_o !== 1'b1) timing_ok = 1'b0;
        end
        step();
        if (valid_o !== 1'b1 || busy_o !== 1'b0) timing_ok = 1'b0;
        u_seen = u_o;
        step();
        if (valid_o !== 1'b0) timing_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick_i = 1'b0; enable_i = 1'b1;
        adc_i = '0; set_i = '0;
        b2_i = '0; b1_i = '0; b0_i = '0; a1_i = '0; a0_i = '0;
        step();
        step();
        tests++;
        if ({u_o, valid_o, busy_o, overrun_o} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got u=%0d v=%0b b=%0b o=%0b expected all 0",
                     u_o, valid_o, busy_o, overrun_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] u;
        bit         ok;
        b2_i = ONE; b1_i = '0; b0_i = '0; a1_i = '0; a0_i = '0;
        set_i = 8'd100; adc_i = 8'd40;
        clear_hist();
        run_tick(u, ok);
        tests++;
        if (u !== 8'd60) begin
            fails++;
            $display("FAIL basic_value: got %0d expected 60", u);
        end
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL basic_timing: got %0b expected 1", ok);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] u;
        bit         ok;
        b2_i = NEAR_TWO; set_i = 8'd255; adc_i = 8'd0;
        run_tick(u, ok);
        tests++;
        if (u !== 8'd255 || ok !== 1'b1) begin
            fails++;
            $display("FAIL clamp_high: got u=%0d timing=%0b expected u=255 timing=1", u, ok);
        end
        b2_i = ONE; set_i = 8'd0; adc_i = 8'd200;
        run_tick(u, ok);
        tests++;
        if (u !== 8'd0 || ok !== 1'b1) begin
            fails++;
            $display("FAIL clamp_low: got u=%0d timing=%0b expected u=0 timing=1", u, ok);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] u;
        bit         ok;
        logic [7:0] exp_u [8] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0};
        b2_i = ONE; a1_i = NEG_ONE;
        clear_hist();
        for (int i = 0; i < 8; i++) begin
            set_i = 8'd50;
            adc_i = (i < 4) ? 8'd40 : 8'd60;
            run_tick(u, ok);
            tests++;
            if (u !== exp_u[i] || ok !== 1'b1) begin
                fails++;
                $display("FAIL accum[%0d]: got u=%0d timing=%0b expected u=%0d timing=1",
                         i, u, ok, exp_u[i]);
            end
        end
    endtask

    task automatic test_windup();
        logic [7:0] u;
        bit         ok;
`ifdef PID_ANTIWINDUP_EN
        logic [7:0] exp_u [6] = '{8'd100, 8'd200, 8'd255, 8'd255, 8'd155, 8'd55};
`else
        logic [7:0] exp_u [6] = '{8'd100, 8'd200, 8'd255, 8'd255, 8'd255, 8'd200};
`endif
        b2_i = ONE; a1_i = NEG_ONE;
        clear_hist();
        for (int i = 0; i < 6; i++) begin
            set_i = (i < 4) ? 8'd150 : 8'd50;
            adc_i = (i < 4) ? 8'd50 : 8'd150;
            run_tick(u, ok);
            tests++;
            if (u !== exp_u[i] || ok !== 1'b1) begin
                fails++;
                $display("FAIL windup[%0d]: got u=%0d timing=%0b expected u=%0d timing=1",
                         i, u, ok, exp_u[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int nvalid = 0;
        b2_i = ONE; a1_i = '0; set_i = 8'd100; adc_i = 8'd40;
        clear_hist();
        tests++;
        if (overrun_o !== 1'b0) begin
            fails++;
            $display("FAIL overrun_initial: got %0b expected 0", overrun_o);
        end
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        step();
        step();
        if (valid_o) nvalid++;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        tests++;
        if (overrun_o !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got %0b expected 1", overrun_o);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid_o) nvalid++;
        end
        tests++;
        if (nvalid !== 1 || u_o !== 8'd60 || overrun_o !== 1'b1) begin
            fails++;
            $display("FAIL overrun_single: got valids=%0d u=%0d ovr=%0b expected 1 60 1",
                     nvalid, u_o, overrun_o);
        end
    endtask

    task automatic test_enable_abort();
        logic [7:0] u;
        bit         ok;
        int         nvalid = 0;
        b2_i = ONE; a1_i = NEG_ONE; set_i = 8'd100; adc_i = 8'd40;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        step();
        step();
        enable_i = 1'b0;
        step();
        enable_i = 1'b1;
        tests++;
        if (u_o !== 8'd0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_outputs: got u=%0d b=%0b v=%0b expected 0 0 0",
                     u_o, busy_o, valid_o);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid_o) nvalid++;
        end
        tests++;
        if (nvalid !== 0) begin
            fails++;
            $display("FAIL abort_no_valid: got %0d expected 0", nvalid);
        end
        // u1 held 60 before the abort; a cleared history gives e alone
        set_i = 8'd45; adc_i = 8'd40;
        run_tick(u, ok);
        tests++;
        if (u !== 8'd5 || ok !== 1'b1) begin
            fails++;
            $display("FAIL abort_hist_cleared: got u=%0d timing=%0b expected u=5 timing=1", u, ok);
        end
    endtask

    task automatic test_reset_mid();
        int nvalid = 0;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests++;
        if ({u_o, valid_o, busy_o, overrun_o} !== 11'd0) begin
            fails++;
            $display("FAIL reset_mid: got u=%0d v=%0b b=%0b o=%0b expected all 0",
                     u_o, valid_o, busy_o, overrun_o);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid_o) nvalid++;
        end
        tests++;
        if (nvalid !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_valid: got %0d expected 0", nvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] first_u = '0;
        int         nvalid = 0;
        b2_i = ONE; a1_i = NEG_ONE; set_i = 8'd45; adc_i = 8'd40;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        // held across the SAT edge (dropped) and the following IDLE edge (accepted)
        tick_i = 1'b1;
        step();
        if (valid_o) nvalid++;
        first_u = u_o;
        step();
        tick_i = 1'b0;
        tests++;
        if (overrun_o !== 1'b1 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL b2b_sat_tick: got ovr=%0b busy=%0b expected 1 1", overrun_o, busy_o);
        end
        tests++;
        if (first_u !== 8'd5) begin
            fails++;
            $display("FAIL b2b_first: got %0d expected 5", first_u);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid_o) nvalid++;
        end
        tests++;
        if (valid_o !== 1'b1 || u_o !== 8'd10 || nvalid !== 2) begin
            fails++;
            $display("FAIL b2b_second: got v=%0b u=%0d valids=%0d expected 1 10 2",
                     valid_o, u_o, nvalid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_accumulate();
        test_windup();
        test_overrun();
        test_enable_abort();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fan_pid_sequencer.md
# fan_pid_sequencer

Time-multiplexed PID update sequencer for the fan controller. On each PID clock-enable tick it samples setpoint and ADC value, forms the error and steps one shared multiply-accumulate unit through the five IIR taps. It then saturates the result, updates the history registers and presents an 8-bit duty command to the PWM stage. It replaces five parallel multipliers with one, trading about 7 cycles of latency per 10 ms update.

## Interface
Parameters:
- ADC_BITWIDTH, 8, width of ADC, setpoint and output command
- COEF_W, 32, signed coefficient width
- FRAC_BITWIDTH, 30, fractional bits in coefficients
- ACC_W, 44, signed accumulator width (≥ COEF_W+ADC_BITWIDTH+4)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- tick_i  in  1  PID clock-enable, one-cycle pulse
- enable_i  in  1  controller enable
- adc_i  in  ADC_BITWIDTH  measured value, unsigned
- set_i  in  ADC_BITWIDTH  setpoint, unsigned
- b2_i, b1_i, b0_i, a1_i, a0_i  in  COEF_W each  signed Q(COEF_W-FRAC).FRAC coefficients, static during a computation
- u_o  out  ADC_BITWIDTH  saturated duty command, unsigned
- valid_o  out  1  one-cycle pulse when u_o updates
- busy_o  out  1  high while in MAC or SAT
- overrun_o  out  1  sticky; set when a tick is dropped because the block is busy

## Operation
- Control law: u[n] = b2·e[n] + b1·e[n-1] + b0·e[n-2] − a1·u[n-1] − a0·u[n-2].
- Error: e = set_i − adc_i, signed ADC_BITWIDTH+1 bits.
- Tap order: 0 = b2·e0, 1 = b1·e1, 2 = b0·e2, 3 = −a1·u1, 4 = −a0·u2.
- The negation is applied to the product. Each product is sign-extended to ACC_W.
- FSM states:
  - IDLE: on tick_i && enable_i, latch e0, clear acc, set tap = 0, go to MAC.
  - MAC: acc += product[tap], tap++. After tap 4, go to SAT.
  - SAT: r = acc >>> FRAC_BITWIDTH (arithmetic shift, floor). Clamp r to [0, 2^ADC_BITWIDTH−1] and write it to u_o. Shift history: e2←e1, e1←e0, u2←u1, u1←hist value. Pulse valid_o. Go to IDLE.
- A tick_i in MAC or SAT is ignored and sets overrun_o.
- A tick_i in IDLE with enable_i low is ignored and does not set overrun_o.
- enable_i low, in any state: next edge forces IDLE and clears e1, e2, u1, u2, acc and u_o to 0. No valid_o is issued. An in-flight computation is discarded.
- Reset values: u_o = 0, valid_o = 0, busy_o = 0, overrun_o = 0, all history and acc = 0, state = IDLE.

## Timing
- tick_i sampled at edge k. MAC accumulates on edges k+1..k+5. SAT completes at edge k+6.
- u_o is updated and valid_o is high in the cycle after edge k+6. valid_o deasserts at edge k+7.
- busy_o is high from edge k through edge k+6.
- The next tick is accepted from edge k+7 onward. Minimum tick spacing is 7 cycles.
- tick_i coincident with the SAT edge is dropped and flagged as overrun.
- rst_n low at any edge overrides everything, including mid-MAC.

## Configuration
- PID_ANTIWINDUP_EN defined: u1 receives the clamped output (back-calculation anti-windup). u1 and u2 are ADC_BITWIDTH+1 bits.
- PID_ANTIWINDUP_EN undefined: u1 receives the unclamped r, saturated to the signed range of ADC_BITWIDTH+8 bits. u1 and u2 are that width. u_o is still clamped.

## Structure
- Package fan_pid_pkg holds:
  - state enum (IDLE, MAC, SAT)
  - tap index constants TAP_B2..TAP_A0
  - width localparams ERR_W and HIST_W
- Sub-module fan_pid_mac: signed multiplier + accumulator with clear, accumulate-enable and negate inputs. The sequencer holds the FSM, operand mux, history and saturation.

## Test plan
- b2 = 2^30, others 0; set = 100, adc = 40, tick → valid_o at k+7 cycle, u_o = 60.
- b2 = 2·2^30; set = 255, adc = 0 → u_o = 255 (clamp high). set = 0, adc = 200, b2 = 2^30 → u_o = 0 (clamp low).
- b2 = 2^30, a1 = −2^30, others 0; set − adc = 10 held; 4 ticks → u_o = 10, 20, 30, 40.
- Repeat the previous case with the error sign flipped after u_o = 40: with the macro, u_o counts down from the clamped state; without it, the recovery delay matches the unclamped history.
- tick at k and k+3 → single valid_o, overrun_o = 1 from edge k+3 until reset.
- enable_i low at k+3 → no valid_o, u_o = 0, history cleared. rst_n low mid-MAC → all outputs at reset values on the next edge.
